// File: rtl/dm_store_controller_pkg.sv
// Shared types and helpers for the MEM-stage store path.
//   UNIT_*        : access size codes (byte, halfword, word, doubleword)
//   sb_entry_t    : one store-buffer entry (doubleword address, lane data, byte enables)
//   size_to_be    : byte-enable pattern for a size at a byte offset (also usable by the load path)
//   is_misaligned : access crosses a doubleword boundary
package dm_store_controller_pkg;

  localparam logic [1:0] UNIT_B  = 2'd0;
  localparam logic [1:0] UNIT_HW = 2'd1;
  localparam logic [1:0] UNIT_W  = 2'd2;
  localparam logic [1:0] UNIT_DW = 2'd3;

  typedef struct packed {
    logic [63:0] dw_addr;
    logic [63:0] wdata;
    logic [7:0]  be;
  } sb_entry_t;

  typedef enum logic {S_IDLE, S_REQ} sb_state_t;

  function automatic logic [3:0] unit_bytes(input logic [1:0] unit);
    case (unit)
      UNIT_B:  return 4'd1;
      UNIT_HW: return 4'd2;
      UNIT_W:  return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [7:0] size_to_be(input logic [1:0] unit, input logic [2:0] off);
    case (unit)
      UNIT_B:  return 8'h01 << off;
      UNIT_HW: return 8'h03 << off;
      UNIT_W:  return 8'h0F << off;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] unit, input logic [2:0] off);
    return ({1'b0, off} + unit_bytes(unit)) > 4'd8;
  endfunction

endpackage

// File: rtl/dm_store_controller_sb_fifo.sv
// In-order store buffer: DEPTH entries of sb_entry_t.
//   push/push_entry : enqueue at tail
//   pop             : drop head (ignored when empty)
//   head/second     : entry at head and the one behind it (next to issue)
//   entries/occ     : every slot plus occupancy mask, for address-conflict compare
//   count           : number of occupied entries (0..DEPTH)
module dm_store_controller_sb_fifo
  import dm_store_controller_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  sb_entry_t                push_entry,
  input  logic                     pop,
  output sb_entry_t                head,
  output sb_entry_t                second,
  output sb_entry_t                entries [DEPTH],
  output logic [DEPTH-1:0]         occ,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sb_entry_t      mem [DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic           do_pop;

  assign do_pop = pop && (count != '0);

  // Storage needs no reset: occupancy is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PW'(1);
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head    = mem[rd_ptr];
  assign second  = mem[rd_ptr + PW'(1)];
  assign entries = mem;

  // Slot i is occupied when its distance from the head is below count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_occ
    logic [PW-1:0] rel;
    assign rel    = PW'(i) - rd_ptr;
    assign occ[i] = {1'b0, rel} < count;
  end

endmodule

// File: rtl/dm_store_controller.sv
// MEM-stage store controller: alignment check, byte-lane formatting, in-order
// store buffer and a req/ack drain to Data Memory.
//   i_st_*               : store request from the pipeline
//   o_st_ready           : buffer has room this cycle
//   o_miss_aligned_error : one-cycle pulse after a rejected misaligned store
//   i_ld_* / o_ld_conflict : load address vs. pending store doublewords
//   o_dm_* / i_dm_ack    : registered write port to Data Memory
//   o_empty              : nothing buffered or in flight
module dm_store_controller
  import dm_store_controller_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_st_valid,
  input  logic [ADDR_W-1:0] i_st_addr,
  input  logic [63:0]       i_st_data,
  input  logic [1:0]        i_st_unit,
  output logic              o_st_ready,
  output logic              o_miss_aligned_error,
  input  logic              i_ld_valid,
  input  logic [ADDR_W-1:0] i_ld_addr,
  output logic              o_ld_conflict,
  output logic              o_dm_req,
  output logic [ADDR_W-1:0] o_dm_addr,
  output logic [63:0]       o_dm_wdata,
  output logic [7:0]        o_dm_be,
  input  logic              i_dm_ack,
  output logic              o_empty
);

  localparam int CW = $clog2(DEPTH) + 1;

  sb_state_t        state_q, state_d;
  sb_entry_t        st_entry, head, second, next_entry, out_q;
  sb_entry_t        entries [DEPTH];
  logic [DEPTH-1:0] occ;
  logic [CW-1:0]    count;
  logic [2:0]       off;
  logic             misaligned, push, pop, load, err_q;
  logic [63:0]      lane, ld_dw;

  assign off        = i_st_addr[2:0];
  assign misaligned = is_misaligned(i_st_unit, off);
  assign o_st_ready = count < CW'(DEPTH);
  assign push       = i_st_valid && !misaligned && o_st_ready;

  // Shift data into its lanes, then keep only the enabled bytes.
  always_comb begin
    st_entry.dw_addr = 64'(i_st_addr) & ~64'h7;
    st_entry.be      = size_to_be(i_st_unit, off);
    lane             = '0;
    for (int b = 0; b < 8; b++) lane[b*8 +: 8] = {8{st_entry.be[b]}};
    st_entry.wdata   = (i_st_data << {off, 3'b000}) & lane;
  end

  dm_store_controller_sb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (st_entry),
    .pop        (pop),
    .head       (head),
    .second     (second),
    .entries    (entries),
    .occ        (occ),
    .count      (count)
  );

  // The next entry to present may be the one being pushed this cycle (empty
  // buffer, or last entry acked alongside a push); bypass it so the request
  // follows one cycle after acceptance.
  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    pop        = 1'b0;
    next_entry = head;
    case (state_q)
      S_IDLE: begin
        if (count != '0 || push) begin
          state_d    = S_REQ;
          load       = 1'b1;
          next_entry = (count != '0) ? head : st_entry;
        end
      end
      S_REQ: begin
        if (i_dm_ack) begin
          pop = 1'b1;
          if (count > CW'(1) || push) begin
            load       = 1'b1;
            next_entry = (count > CW'(1)) ? second : st_entry;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) out_q <= next_entry;
      err_q   <= i_st_valid && misaligned;
    end
  end

  assign o_dm_req             = (state_q == S_REQ);
  assign o_dm_addr            = out_q.dw_addr[ADDR_W-1:0];
  assign o_dm_wdata           = out_q.wdata;
  assign o_dm_be              = out_q.be;
  assign o_miss_aligned_error = err_q;
  assign o_empty              = (count == '0) && (state_q == S_IDLE);

  // The head stays in the buffer until acked, so in-flight writes are covered.
  assign ld_dw = 64'(i_ld_addr) & ~64'h7;
  always_comb begin
    o_ld_conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (i_ld_valid && occ[i] && entries[i].dw_addr == ld_dw) o_ld_conflict = 1'b1;
  end

endmodule

// File: tb/tb_dm_store_controller.sv
module tb_dm_store_controller;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              i_st_valid = 1'b0;
  logic [ADDR_W-1:0] i_st_addr = '0;
  logic [63:0]       i_st_data = '0;
  logic [1:0]        i_st_unit = '0;
  logic              o_st_ready, o_miss_aligned_error;
  logic              i_ld_valid = 1'b0;
  logic [ADDR_W-1:0] i_ld_addr = '0;
  logic              o_ld_conflict, o_dm_req;
  logic [ADDR_W-1:0] o_dm_addr;
  logic [63:0]       o_dm_wdata;
  logic [7:0]        o_dm_be;
  logic              i_dm_ack = 1'b0;
  logic              o_empty;

  always #5 clk = ~clk;

  dm_store_controller #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .i_st_valid(i_st_valid), .i_st_addr(i_st_addr), .i_st_data(i_st_data), .i_st_unit(i_st_unit),
    .o_st_ready(o_st_ready), .o_miss_aligned_error(o_miss_aligned_error),
    .i_ld_valid(i_ld_valid), .i_ld_addr(i_ld_addr), .o_ld_conflict(o_ld_conflict),
    .o_dm_req(o_dm_req), .o_dm_addr(o_dm_addr), .o_dm_wdata(o_dm_wdata), .o_dm_be(o_dm_be),
    .i_dm_ack(i_dm_ack), .o_empty(o_empty)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  be;
  } wr_t;

  wr_t  model_q [$];   // stores pending in the buffer at the start of the cycle
  wr_t  exp_q   [$];   // scoreboard of writes memory should see, in order
  logic exp_err = 1'b0;

  function automatic bit ref_misaligned(input logic [1:0] u, input logic [63:0] a);
    return ((a % 8) + (1 << u)) > 8;
  endfunction

  function automatic wr_t ref_write(input logic [1:0] u, input logic [63:0] a, input logic [63:0] d);
    wr_t w;
    int  n   = 1 << u;
    int  off = int'(a % 8);
    w.addr = a - 64'(off);
    w.be   = 8'(((1 << n) - 1) << off);
    w.data = '0;
    for (int k = 0; k < n; k++) w.data[(off + k) * 8 +: 8] = d[k * 8 +: 8];
    return w;
  endfunction

  // Predictor: decides acceptance from the model occupancy and pushes expectations.
  wr_t p_w;
  bit  p_rdy;
  always @(posedge clk) begin
    if (rst) begin
      model_q.delete();
      exp_q.delete();
      exp_err = 1'b0;
    end else begin
      p_rdy = model_q.size() < DEPTH;
      if (i_dm_ack && model_q.size() > 0) void'(model_q.pop_front());
      exp_err = i_st_valid && ref_misaligned(i_st_unit, i_st_addr);
      if (i_st_valid && p_rdy && !ref_misaligned(i_st_unit, i_st_addr)) begin
        p_w = ref_write(i_st_unit, i_st_addr, i_st_data);
        model_q.push_back(p_w);
        exp_q.push_back(p_w);
      end
    end
  end

  // Monitor: compares status against the model and every presented write against the scoreboard.
  bit m_conf;
  always @(negedge clk) begin
    if (!rst) begin
      chk("st_ready", 64'(o_st_ready), 64'(model_q.size() < DEPTH));
      chk("empty", 64'(o_empty), 64'(model_q.size() == 0));
      chk("dm_req", 64'(o_dm_req), 64'(model_q.size() != 0));
      chk("misalign_err", 64'(o_miss_aligned_error), 64'(exp_err));
      m_conf = 1'b0;
      foreach (model_q[k])
        if (i_ld_valid && model_q[k].addr == (i_ld_addr & ~64'h7)) m_conf = 1'b1;
      chk("ld_conflict", 64'(o_ld_conflict), 64'(m_conf));
      if (o_dm_req) begin
        if (exp_q.size() == 0) chk("unexpected_req", 64'(1), 64'(0));
        else begin
          chk("dm_addr", o_dm_addr, exp_q[0].addr);
          chk("dm_be", 64'(o_dm_be), 64'(exp_q[0].be));
          chk("dm_wdata", o_dm_wdata, exp_q[0].data);
          if (i_dm_ack) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_store(input bit v, input logic [1:0] u, input logic [63:0] a, input logic [63:0] d);
    i_st_valid = v;
    i_st_unit  = u;
    i_st_addr  = a;
    i_st_data  = d;
  endtask

  logic [63:0] bases [4] = '{64'h1000, 64'h1008, 64'h2000, 64'h3000};

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("rst_ready", 64'(o_st_ready), 64'(1));
    chk("rst_empty", 64'(o_empty), 64'(1));
    chk("rst_req", 64'(o_dm_req), 64'(0));
    chk("rst_err", 64'(o_miss_aligned_error), 64'(0));
    step(); step();
    rst = 1'b0;
    step();

    // Byte store with ack held high.
    i_dm_ack = 1'b1;
    set_store(1, 2'd0, 64'h1003, 64'hAB);
    step();
    set_store(0, 2'd0, 0, 0);
    chk("byte_req", 64'(o_dm_req), 64'(1));
    chk("byte_addr", o_dm_addr, 64'h1000);
    chk("byte_be", 64'(o_dm_be), 64'h08);
    chk("byte_wdata", o_dm_wdata, 64'h0000_0000_AB00_0000);
    step();
    chk("byte_empty_after", 64'(o_empty), 64'(1));
    i_dm_ack = 1'b0;

    // Misaligned word rejected, halfword at the same offset accepted.
    set_store(1, 2'd2, 64'h2006, 64'h1122_3344);
    step();
    set_store(0, 2'd0, 0, 0);
    chk("mis_pulse", 64'(o_miss_aligned_error), 64'(1));
    chk("mis_no_req", 64'(o_dm_req), 64'(0));
    step();
    chk("mis_pulse_end", 64'(o_miss_aligned_error), 64'(0));
    set_store(1, 2'd1, 64'h2006, 64'h5555_1234);
    step();
    set_store(0, 2'd0, 0, 0);
    chk("hw_be", 64'(o_dm_be), 64'hC0);
    chk("hw_wdata", o_dm_wdata, 64'h1234_0000_0000_0000);
    i_dm_ack = 1'b1;
    step();
    i_dm_ack = 1'b0;

    // Fill the buffer, hold a fifth store, release one slot.
    for (int i = 0; i < 4; i++) begin
      set_store(1, 2'd3, 64'(i * 8), {$urandom, $urandom});
      step();
    end
    set_store(1, 2'd3, 64'h20, 64'hDEAD_BEEF_0000_0005);
    chk("full_not_ready", 64'(o_st_ready), 64'(0));
    step(); step();
    i_dm_ack = 1'b1;
    step();
    i_dm_ack = 1'b0;
    chk("ready_after_ack", 64'(o_st_ready), 64'(1));
    step();
    set_store(0, 2'd0, 0, 0);
    i_dm_ack = 1'b1;
    for (int i = 0; i < 6; i++) step();
    i_dm_ack = 1'b0;

    // Two pending, then push and ack together for several cycles (pointer wrap).
    for (int i = 0; i < 2; i++) begin
      set_store(1, 2'd2, 64'h4000 + 64'(i * 8), {$urandom, $urandom});
      step();
    end
    i_dm_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_store(1, 2'd2, 64'h4104 + 64'(i * 8), {$urandom, $urandom});
      step();
      chk("pushpop_ready", 64'(o_st_ready), 64'(1));
    end
    set_store(0, 2'd0, 0, 0);
    for (int i = 0; i < 4; i++) step();
    i_dm_ack = 1'b0;

    // Load conflict against a pending word store.
    set_store(1, 2'd2, 64'h3004, 64'h0BAD_F00D);
    step();
    set_store(0, 2'd0, 0, 0);
    i_ld_valid = 1'b1;
    i_ld_addr  = 64'h3000;
    #1 chk("conflict_hit", 64'(o_ld_conflict), 64'(1));
    i_ld_addr  = 64'h3008;
    #1 chk("conflict_miss", 64'(o_ld_conflict), 64'(0));
    i_ld_addr  = 64'h3000;
    i_dm_ack   = 1'b1;
    step();
    i_dm_ack   = 1'b0;
    #1 chk("conflict_drained", 64'(o_ld_conflict), 64'(0));
    i_ld_valid = 1'b0;

    // Reset while a write is in flight with three entries buffered.
    for (int i = 0; i < 3; i++) begin
      set_store(1, 2'd3, 64'h5000 + 64'(i * 8), {$urandom, $urandom});
      step();
    end
    set_store(0, 2'd0, 0, 0);
    chk("pre_rst_req", 64'(o_dm_req), 64'(1));
    #2 rst = 1'b1;
    #1;
    chk("async_rst_req", 64'(o_dm_req), 64'(0));
    chk("async_rst_empty", 64'(o_empty), 64'(1));
    chk("async_rst_ready", 64'(o_st_ready), 64'(1));
    step();
    rst = 1'b0;
    i_dm_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_no_req", 64'(o_dm_req), 64'(0));
    end

    // Randomized traffic.
    for (int c = 0; c < 800; c++) begin
      set_store(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                bases[$urandom_range(0, 3)] + 64'($urandom_range(0, 15)), {$urandom, $urandom});
      i_dm_ack   = ($urandom_range(0, 2) != 0);
      i_ld_valid = 1'($urandom_range(0, 1));
      i_ld_addr  = bases[$urandom_range(0, 3)] + 64'($urandom_range(0, 15));
      step();
    end

    // Drain with a bounded wait.
    set_store(0, 2'd0, 0, 0);
    i_ld_valid = 1'b0;
    i_dm_ack   = 1'b1;
    for (int c = 0; c < 20 && !o_empty; c++) step();
    chk("drain_empty", 64'(o_empty), 64'(1));
    step();
    chk("scoreboard_left", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dm_store_controller.md
Name: dm_store_controller

Overview:
- MEM-stage store path; the write-direction counterpart of the load controller.
- Accepts store requests from the pipeline, checks alignment, and converts each store into a doubleword-aligned write with shifted data and byte enables.
- Buffers accepted stores in a small in-order FIFO and drains them to Data Memory over a req/ack handshake.
- Flags pending-store/load address conflicts so the hazard unit can stall loads.

Parameters:
DEPTH, 4, store buffer entries (power of two, >=2)
ADDR_W, 64, byte address width

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active-high
i_st_valid  in  1  store request valid (already qualified by is_valid && mem_wr)
i_st_addr  in  ADDR_W  store byte address
i_st_data  in  64  store data, right-justified
i_st_unit  in  2  access size: `B, `HW, `W, `DW
o_st_ready  out  1  buffer can accept a store this cycle
o_miss_aligned_error  out  1  registered one-cycle pulse: rejected misaligned store
i_ld_valid  in  1  load in MEM stage
i_ld_addr  in  ADDR_W  load byte address
o_ld_conflict  out  1  load overlaps a buffered or in-flight store doubleword
o_dm_req  out  1  write request to Data Memory
o_dm_addr  out  ADDR_W  doubleword-aligned write address (addr[2:0]=0)
o_dm_wdata  out  64  write data, byte-lane positioned
o_dm_be  out  8  byte enables
i_dm_ack  in  1  memory accepted the current write
o_empty  out  1  no buffered or in-flight stores (fence/drain indication)

Behaviour:
- Reset: all outputs 0 except o_st_ready=1 and o_empty=1; FIFO pointers and count cleared; FSM=IDLE. Reset mid-transaction drops all entries and deasserts o_dm_req; memory must not complete a write whose req has fallen.
- Offset: off = i_st_addr[2:0]. Misaligned when off + size > 8, with size 1/2/4/8:
  - `HW: off=7
  - `W: off=5..7
  - `DW: off!=0
  - `B: never misaligned
- Accept: push when i_st_valid && o_st_ready && aligned.
- Reject: i_st_valid && misaligned enqueues nothing. o_miss_aligned_error=1 on the next cycle for exactly one cycle, independent of o_st_ready.
- i_st_valid && !o_st_ready && aligned: ignored. The pipeline must stall and hold the request.
- Entry contents:
  - dw_addr = {addr[ADDR_W-1:3], 3'b000}
  - be: `B 8'h01<<off, `HW 8'h03<<off, `W 8'h0F<<off, `DW 8'hFF
  - wdata = (i_st_data masked to size) << (off*8); unused lanes 0
- o_st_ready = (count < DEPTH), registered from count. It does not depend on i_dm_ack in the same cycle.
- Drain FSM:
  - IDLE: if count>0, go to REQ with o_dm_req=1 and o_dm_addr/wdata/be = head entry, all registered.
  - REQ: outputs held stable until i_dm_ack=1. On ack, pop the head. If entries remain after the pop, stay in REQ with the next head presented the following cycle; otherwise go to IDLE with o_dm_req=0.
  - Minimum latency: store accepted in cycle N, o_dm_req=1 in cycle N+1. With ack in N+1, the entry is popped at the end of N+1.
  - i_dm_ack when o_dm_req=0: ignored.
- Simultaneous push and pop: count unchanged; FIFO order preserved; pointers wrap modulo DEPTH.
- o_ld_conflict (combinational): i_ld_valid && any occupied entry, including the in-flight head, has dw_addr == {i_ld_addr[ADDR_W-1:3],3'b000}. A same-cycle incoming store is excluded because program order places it after the load.
- o_empty = (count==0) && FSM==IDLE.

Decomposition:
- struct_pckg: add sb_entry_t {dw_addr, wdata[`RNG_64], be[7:0]}. Size codes `B/`HW/`W/`DW come from the shared defines; no new codes.
- Function size_to_be(unit, off) lives in struct_pckg; it is reusable by the load path.
- One sub-module: sb_fifo (DEPTH x sb_entry_t, push/pop/count, parallel read of all entries for conflict compare). The controller holds alignment, lane formatting and the drain FSM.

Test Plan:
- Byte store: addr=0x1003, data=0xAB, `B; ack held high -> next cycle o_dm_req=1, addr=0x1000, be=8'h08, wdata=64'h0000_0000_AB00_0000; popped; o_empty=1 one cycle later.
- Misalignment: `W at addr 0x2006 -> nothing enqueued, o_miss_aligned_error pulse 1 cycle, o_dm_req stays 0. `HW at 0x2006 is accepted: be=8'hC0, wdata=data[15:0]<<48.
- Full buffer: 4 `DW stores at 0x0,0x8,0x10,0x18 with ack=0 -> o_st_ready=0 after the 4th; a 5th store is held. One ack -> o_st_ready=1 next cycle; writes issue in order 0x0,0x8,0x10,0x18.
- Simultaneous push and pop: count=2, push and ack in the same cycle -> count stays 2; order intact across pointer wrap.
- Load conflict: `W store pending at 0x3004, load at 0x3000 -> o_ld_conflict=1. Load at 0x3008 -> 0. After the ack that drains the store -> 0.
- Reset mid-transaction: o_dm_req=1 with 3 entries, assert rst -> o_dm_req=0, o_empty=1, o_st_ready=1 asynchronously. After release, no write issues.
